// File: rtl/reg_file_wb_pkg.sv
// Shared types and constants for the 32x32 register file with its write-back staging register.
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0]   reg_addr_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [NUM_REGS-1:0] row_sel_t;
endpackage

// File: rtl/reg_file_wb_if.sv
// Write request, two read ports and write-back status of the register file.
interface reg_file_wb_if #(
    parameter int DATA_W = 32
);
    import regfile_pkg::*;

    logic              wr_en;
    reg_addr_t         wr_addr;
    logic [DATA_W-1:0] wr_data;
    reg_addr_t         rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    reg_addr_t         rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wb_pending;
    row_sel_t          wb_sel;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_pending, wb_sel
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_pending, wb_sel
    );
endinterface

// File: rtl/reg_file_wb_decoder.sv
// 5-to-32 one-hot row decoder; all rows low while en is low.
module decoder_5to32 (
    input  logic [4:0]  sel,
    input  logic        en,
    output logic [31:0] y
);
    // One-hot row enable for the selected address
    always_comb begin
        y = 32'h0;
        if (en) begin
            y = 32'h1 << sel;
        end else begin
            y = 32'h0;
        end
    end
endmodule

// File: rtl/reg_file_wb.sv
// 32-entry register file: writes are staged one cycle, read ports bypass from the stage.
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_wb_if.slave  bus
);
    import regfile_pkg::*;

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic              stg_valid_r;
    reg_addr_t         stg_addr_r;
    logic [DATA_W-1:0] stg_data_r;
    row_sel_t          wb_sel_r;

    logic              wr_accept_s;
    row_sel_t          dec_sel_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // Writes to a hardwired-zero entry never reach the staging register
    assign wr_accept_s = bus.wr_en & ~(ZERO_REG & (bus.wr_addr == 5'd0));

    decoder_5to32 u_dec (
        .sel (bus.wr_addr),
        .en  (wr_accept_s),
        .y   (dec_sel_s)
    );

    // Stage capture and array commit share one edge, so back-to-back writes never stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_r <= 1'b0;
            stg_addr_r  <= 5'd0;
            stg_data_r  <= {DATA_W{1'b0}};
            wb_sel_r    <= 32'h0;
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            stg_valid_r <= wr_accept_s;
            wb_sel_r    <= dec_sel_s;
            // Address/data only captured for real writes so idle X never enters state
            if (wr_accept_s) begin
                stg_addr_r <= bus.wr_addr;
                stg_data_r <= bus.wr_data;
            end else begin
                stg_addr_r <= stg_addr_r;
                stg_data_r <= stg_data_r;
            end
            if (stg_valid_r) begin
                mem_r[stg_addr_r] <= stg_data_r;
            end else begin
                mem_r[stg_addr_r] <= mem_r[stg_addr_r];
            end
        end
    end

    // Read port A: zero entry, then pending write-back, then array
    always_comb begin
        rd_a_s = {DATA_W{1'b0}};
        if (ZERO_REG && (bus.rd_addr_a == 5'd0)) begin
            rd_a_s = {DATA_W{1'b0}};
        end else if (stg_valid_r && (stg_addr_r == bus.rd_addr_a)) begin
            rd_a_s = stg_data_r;
        end else begin
            rd_a_s = mem_r[bus.rd_addr_a];
        end
    end

    // Read port B: same priority as port A
    always_comb begin
        rd_b_s = {DATA_W{1'b0}};
        if (ZERO_REG && (bus.rd_addr_b == 5'd0)) begin
            rd_b_s = {DATA_W{1'b0}};
        end else if (stg_valid_r && (stg_addr_r == bus.rd_addr_b)) begin
            rd_b_s = stg_data_r;
        end else begin
            rd_b_s = mem_r[bus.rd_addr_b];
        end
    end

    assign bus.rd_data_a  = rd_a_s;
    assign bus.rd_data_b  = rd_b_s;
    assign bus.wb_pending = stg_valid_r;
    assign bus.wb_sel     = wb_sel_r;
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed plus random bench for reg_file_wb, run with ZERO_REG=1 and ZERO_REG=0 side by side.
module tb_reg_file_wb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_wb_if #(.DATA_W(32)) bz ();
    reg_file_wb_if #(.DATA_W(32)) bn ();

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_z (
        .clk (clk), .rst (rst), .bus (bz.slave)
    );
    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_n (
        .clk (clk), .rst (rst), .bus (bn.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: contents as seen through the read ports (index 0: ZERO_REG=0, 1: ZERO_REG=1)
    logic [31:0] mdl [2][32];
    logic        exp_pend [2];
    logic [31:0] exp_sel [2];

    logic        cur_en;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int z, input logic [4:0] a);
        if (z == 1 && a == 5'd0) return 32'h0;
        return mdl[z][a];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 32; i++) mdl[z][i] = 32'h0;
            exp_pend[z] = 1'b0;
            exp_sel[z]  = 32'h0;
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        cur_en = en; cur_wa = wa; cur_wd = wd;
        bz.wr_en = en; bz.wr_addr = wa; bz.wr_data = wd; bz.rd_addr_a = ra; bz.rd_addr_b = rb;
        bn.wr_en = en; bn.wr_addr = wa; bn.wr_data = wd; bn.rd_addr_a = ra; bn.rd_addr_b = rb;
    endtask

    // A write becomes visible right after its edge; later writes simply overwrite
    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (cur_en && !(z == 1 && cur_wa == 5'd0)) begin
                    mdl[z][cur_wa] = cur_wd;
                    exp_pend[z]    = 1'b1;
                    exp_sel[z]     = 32'h1 << cur_wa;
                end else begin
                    exp_pend[z] = 1'b0;
                    exp_sel[z]  = 32'h0;
                end
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_z_a"},    bz.rd_data_a, exp_rd(1, bz.rd_addr_a));
        chk({tag, "_z_b"},    bz.rd_data_b, exp_rd(1, bz.rd_addr_b));
        chk({tag, "_z_pend"}, {31'h0, bz.wb_pending}, {31'h0, exp_pend[1]});
        chk({tag, "_z_sel"},  bz.wb_sel, exp_sel[1]);
        chk({tag, "_n_a"},    bn.rd_data_a, exp_rd(0, bn.rd_addr_a));
        chk({tag, "_n_b"},    bn.rd_data_b, exp_rd(0, bn.rd_addr_b));
        chk({tag, "_n_pend"}, {31'h0, bn.wb_pending}, {31'h0, exp_pend[0]});
        chk({tag, "_n_sel"},  bn.wb_sel, exp_sel[0]);
    endtask

    task automatic read_sweep(input string tag);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'h0, a[4:0], 5'(31 - a));
            #1;
            check_all(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (2) clock_edge();
        rst = 1'b0;
        read_sweep("reset");
        clock_edge();

        // Basic write and bypass visibility
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        #1;
        check_all("same_cycle_old");
        clock_edge();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check_all("bypass");
        chk("bypass_lit", bz.rd_data_a, 32'hDEADBEEF);
        chk("sel_lit", bz.wb_sel, 32'h0000_0020);
        clock_edge();
        check_all("committed");
        chk("committed_lit", bn.rd_data_a, 32'hDEADBEEF);

        // Back-to-back writes to one address
        drive(1'b1, 5'd7, 32'h11, 5'd7, 5'd7);
        clock_edge();
        check_all("b2b_first");
        drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
        #1;
        check_all("b2b_first_hold");
        clock_edge();
        check_all("b2b_second");
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        clock_edge();
        check_all("b2b_final");
        chk("b2b_lit", bz.rd_data_b, 32'h22);

        // Entry 0 with and without hardwired zero
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        clock_edge();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check_all("r0_write");
        clock_edge();
        check_all("r0_commit");
        chk("r0_n_lit", bn.rd_data_a, 32'hFFFFFFFF);

        // Full sweep with one-hot walk
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, i[4:0], i * 32'h01010101, 5'(i), 5'(31 - i));
            clock_edge();
            check_all("sweep_wr");
            chk("sweep_sel_n", bn.wb_sel, 32'h1 << i);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        clock_edge();
        read_sweep("sweep_rd");

        // Random traffic, read ports sampled before and after each edge
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            #1;
            check_all("rand_pre");
            clock_edge();
            check_all("rand_post");
        end

        // Asynchronous reset between edges
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        clock_edge();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        clock_edge();
        rst = 1'b0;
        read_sweep("async_rst_sweep");
        clock_edge();

        // Reset discards a pending write
        drive(1'b1, 5'd9, 32'h0000ABCD, 5'd9, 5'd9);
        clock_edge();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1;
        check_all("mid_pending");
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("mid_rst");
        clock_edge();
        rst = 1'b0;
        repeat (3) clock_edge();
        check_all("mid_after");
        chk("mid_after_lit", bn.rd_data_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
